prod_accumulator: RTL and testbench

- Sequential consumer placed directly downstream of the 8x8 CLA array multiplier.
- Accepts a stream of 16-bit unsigned products over a valid/ready handshake and sums a programmed number of them into a wide accumulator.
- Presents the dot-product result on a second valid/ready handshake.
- Turns the combinational multiplier into a usable multiply-accumulate datapath.

---
 rtl/prod_accumulator.sv | 131 +++++++++++++
 tb/tb_prod_accumulator.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prod_accumulator.sv
// ---------------------------------------------------------------------------
// prod_accumulator
//
// Multiply-accumulate back end for the 8x8 CLA array multiplier. A burst of
// `len` unsigned 16-bit products is accepted over a valid/ready handshake and
// summed into an ACC_W-bit accumulator. The sum is then offered on a second
// valid/ready handshake. Every output is a flop, so no input reaches an
// output combinationally.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle burst request, honoured only while idle
//   len         number of products in the burst (sampled with start)
//   prod_in     unsigned product from the multiplier
//   prod_valid  prod_in is valid
//   prod_ready  block accepts prod_in this cycle (high only while accumulating)
//   acc_out     accumulated sum, meaningful while out_valid is high
//   out_valid   result available
//   out_ready   consumer accepts the result
//   busy        accumulating or holding a result
//   ovf         sticky carry out of the accumulator MSB for the current burst
// ---------------------------------------------------------------------------
module prod_accumulator #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             ovf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [LEN_W-1:0] rem_r;
    logic [LEN_W-1:0] rem_s;
    logic [ACC_W-1:0] acc_s;
    logic             ovf_s;
    logic [ACC_W:0]   sum_s;

    // Next-state, next-accumulator and next-flag logic.
    always_comb begin
        state_s = state_r;
        rem_s   = rem_r;
        acc_s   = acc_out;
        ovf_s   = ovf;
        // One extra bit captures the carry out of the accumulator MSB.
        sum_s   = {1'b0, acc_out} + {{(ACC_W-15){1'b0}}, prod_in};
        case (state_r)
            IDLE: begin
                if (start) begin
                    acc_s = {ACC_W{1'b0}};
                    ovf_s = 1'b0;
                    if (len != LEN_ZERO) begin
                        rem_s   = len;
                        state_s = ACC;
                    end else begin
                        // Empty burst reports a zero result immediately.
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACC: begin
                // prod_ready is the registered image of state ACC.
                if (prod_valid && prod_ready) begin
                    acc_s = sum_s[ACC_W-1:0];
                    ovf_s = ovf | sum_s[ACC_W];
                    rem_s = rem_r - LEN_ONE;
                    if (rem_r == LEN_ONE) begin
                        state_s = DONE;
                    end else begin
                        state_s = ACC;
                    end
                end else begin
                    state_s = ACC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and handshake registers; outputs decoded from the next
    // state so that they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            rem_r      <= LEN_ZERO;
            acc_out    <= {ACC_W{1'b0}};
            ovf        <= 1'b0;
            prod_ready <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            rem_r      <= rem_s;
            acc_out    <= acc_s;
            ovf        <= ovf_s;
            prod_ready <= (state_s == ACC);
            out_valid  <= (state_s == DONE);
            busy       <= (state_s != IDLE);
        end
    end

endmodule

// File: tb/tb_prod_accumulator.sv
// ---------------------------------------------------------------------------
// Self-checking bench for prod_accumulator. Two instances (ACC_W = 18 and
// ACC_W = 24) share one stimulus stream. A reference model tracks the burst
// phase and the exact (unbounded) sum of accepted products; the expected
// accumulator is that sum reduced modulo 2^ACC_W and the expected overflow
// flag is "the exact sum reached 2^ACC_W".
// ---------------------------------------------------------------------------
module tb_prod_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [15:0] prod_in;
    logic        prod_valid;
    logic        out_ready;

    logic        pr18, ov18, busy18, ovf18;
    logic [17:0] acc18;
    logic        pr24, ov24, busy24, ovf24;
    logic [23:0] acc24;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    localparam longint M18 = 64'd1 << 18;
    localparam longint M24 = 64'd1 << 24;

    // Reference model state: 0 idle, 1 accumulating, 2 result held.
    int     m_phase = 0;
    longint m_sum   = 0;
    int     m_left  = 0;

    always #5 clk = ~clk;

    prod_accumulator #(.ACC_W(18), .LEN_W(8)) dut18 (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod_in(prod_in),
        .prod_valid(prod_valid), .prod_ready(pr18), .acc_out(acc18),
        .out_valid(ov18), .out_ready(out_ready), .busy(busy18), .ovf(ovf18)
    );

    prod_accumulator #(.ACC_W(24), .LEN_W(8)) dut24 (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod_in(prod_in),
        .prod_valid(prod_valid), .prod_ready(pr24), .acc_out(acc24),
        .out_valid(ov24), .out_ready(out_ready), .busy(busy24), .ovf(ovf24)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model update on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_sum   = 0;
            m_left  = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_sum = 0;
                    if (len != 8'd0) begin
                        m_phase = 1;
                        m_left  = int'(len);
                    end else begin
                        m_phase = 2;
                    end
                end
                1: if (prod_valid) begin
                    m_sum  = m_sum + longint'(prod_in);
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = 2;
                end
                2: if (out_ready) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("prod_ready18", longint'(pr18), longint'(m_phase == 1));
            chk("out_valid18", longint'(ov18), longint'(m_phase == 2));
            chk("busy18", longint'(busy18), longint'(m_phase != 0));
            chk("acc18", longint'(acc18), m_sum % M18);
            chk("ovf18", longint'(ovf18), longint'(m_sum >= M18));
            chk("prod_ready24", longint'(pr24), longint'(m_phase == 1));
            chk("out_valid24", longint'(ov24), longint'(m_phase == 2));
            chk("busy24", longint'(busy24), longint'(m_phase != 0));
            chk("acc24", longint'(acc24), m_sum % M24);
            chk("ovf24", longint'(ovf24), longint'(m_sum >= M24));
        end
    end

    task automatic start_burst(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // Offer one product after `gap` idle cycles; optionally pulse start in the gap.
    task automatic send(input logic [15:0] p, input int gap, input bit poke);
        int n;
        prod_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (poke && g == 0) begin
                start = 1'b1;
                len   = 8'($urandom_range(1, 200));
            end
            tick();
            start = 1'b0;
        end
        prod_in    = p;
        prod_valid = 1'b1;
        n = 0;
        while (!pr24 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) timeout("prod_ready_wait");
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!ov24 && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) timeout("out_valid_wait");
    endtask

    task automatic drain(input int hold);
        out_ready = 1'b0;
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l, k;
        bit abort;
        rst = 1'b1; start = 1'b0; len = 8'd0; prod_in = 16'd0;
        prod_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_acc", longint'(acc24), 64'd0);
        chk("reset_ready", longint'(pr24), 64'd0);
        rst = 1'b0;
        tick();

        // Basic burst, back to back.
        start_burst(8'd3);
        send(16'd38000, 0, 1'b0);
        send(16'd12816, 0, 1'b0);
        send(16'd1000, 0, 1'b0);
        chk("basic_valid", longint'(ov24), 64'd1);
        chk("basic_acc", longint'(acc24), 64'd51816);
        chk("basic_ovf", longint'(ovf24), 64'd0);
        drain(0);

        // Gapped input and backpressure.
        start_burst(8'd2);
        send(16'd65025, 0, 1'b0);
        send(16'd22287, 3, 1'b0);
        out_ready = 1'b0;
        repeat (5) tick();
        chk("gap_hold_valid", longint'(ov24), 64'd1);
        chk("gap_acc", longint'(acc24), 64'd87312);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("gap_valid_drop", longint'(ov24), 64'd0);

        // Overflow on the 18-bit instance, then a clearing burst.
        start_burst(8'd5);
        repeat (5) send(16'd65025, 0, 1'b0);
        chk("ovf_acc18", longint'(acc18), 64'd62981);
        chk("ovf_flag18", longint'(ovf18), 64'd1);
        chk("ovf_acc24", longint'(acc24), 64'd325125);
        drain(1);
        start_burst(8'd1);
        send(16'd2, 0, 1'b0);
        chk("clear_acc18", longint'(acc18), 64'd2);
        chk("clear_ovf18", longint'(ovf18), 64'd0);
        drain(0);

        // Zero-length burst.
        start_burst(8'd0);
        chk("zero_valid", longint'(ov24), 64'd1);
        chk("zero_acc", longint'(acc24), 64'd0);
        drain(2);

        // Full-length burst.
        start_burst(8'd255);
        repeat (255) send(16'd65025, 0, 1'b0);
        chk("full_acc24", longint'(acc24), 64'd16581375);
        chk("full_ovf24", longint'(ovf24), 64'd0);
        chk("full_acc18", longint'(acc18), 64'd66303);
        drain(0);

        // Reset mid-burst.
        start_burst(8'd4);
        send(16'd100, 0, 1'b0);
        send(16'd200, 0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", longint'(ov24), 64'd0);
        chk("rst_acc", longint'(acc24), 64'd0);
        chk("rst_ready", longint'(pr24), 64'd0);

        // Start pulse during ACC is ignored.
        start_burst(8'd3);
        send(16'd10, 0, 1'b0);
        send(16'd20, 2, 1'b1);
        send(16'd30, 0, 1'b0);
        chk("ignored_start_acc", longint'(acc24), 64'd60);
        chk("ignored_start_valid", longint'(ov24), 64'd1);
        drain(0);

        // Randomized bursts with gaps, ignored starts, backpressure and resets.
        for (int it = 0; it < 40; it++) begin
            l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
            abort = ($urandom_range(0, 7) == 0) && (l > 1);
            start_burst(8'(l));
            k = 0;
            for (int j = 0; j < l; j++) begin
                if (abort && j == l / 2) break;
                send(16'($urandom), int'($urandom_range(0, 2)), $urandom_range(0, 5) == 0);
                k++;
            end
            if (abort && k < l) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                wait_done();
                drain(int'($urandom_range(0, 3)));
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
